// File: rtl/melody_pkg.sv
// Shared state encoding, default timing constants and note helpers for melody_seq.
package melody_pkg;

    typedef enum logic [1:0] {StIdle, StNote, StGap, StFin} state_t;

    localparam int unsigned DEF_CLK_DIV    = 50000;
    localparam int unsigned DEF_NOTE_TICKS = 400;
    localparam int unsigned DEF_GAP_TICKS  = 100;
    localparam int unsigned DEF_MAX_SCALE  = 15;

    function automatic logic [4:0] clamp_level(input logic [4:0] lvl, input logic [4:0] max_lvl);
        return (lvl > max_lvl) ? max_lvl : lvl;
    endfunction

    // Scale notes come first; the note at position lvl is the target.
    function automatic logic [4:0] note_index(input logic [4:0] k, input logic [4:0] lvl,
                                              input logic [3:0] snd);
        return (k < lvl) ? k : {1'b0, snd};
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_DIV cycles; clr restarts the count.
module tick_prescaler
    import melody_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_eff;

    // clr acts in the first cycle of a state, so that cycle already counts as 0.
    always_comb begin
        cnt_eff = clr ? '0 : cnt_q;
        tick    = (cnt_eff == LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_eff + 1'b1;
        end
    end

endmodule

// File: rtl/melody_seq.sv
// Plays level ascending scale notes then a target note, with timed gaps.
// Optional replay of the last sequence is enabled by defining MELODY_REPLAY_EN.
module melody_seq
    import melody_pkg::*;
#(
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned NOTE_TICKS = DEF_NOTE_TICKS,
    parameter int unsigned GAP_TICKS  = DEF_GAP_TICKS,
    parameter int unsigned MAX_SCALE  = DEF_MAX_SCALE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic [4:0] level,
    input  logic [3:0] sound,
    input  logic       replay,
    output logic [4:0] play_index,
    output logic       tone_en,
    output logic       busy,
    output logic       done
);

    localparam int unsigned TMAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] NOTE_LAST = TW'(NOTE_TICKS - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(GAP_TICKS - 1);
    localparam logic [4:0]    MAX_LVL   = 5'(MAX_SCALE);

    state_t        state;
    logic [4:0]    lvl_q;
    logic [3:0]    snd_q;
    logic [4:0]    note_cnt;
    logic [4:0]    next_cnt;
    logic [TW-1:0] tick_cnt;
    logic          entry;
    logic          tick;
    logic          go;
    logic [4:0]    lvl_n;
    logic [3:0]    snd_n;

`ifdef MELODY_REPLAY_EN
    // start wins over replay; replay reuses the latched pair untouched.
    always_comb begin
        go = start | replay;
        if (start) begin
            lvl_n = clamp_level(level, MAX_LVL);
            snd_n = sound;
        end else begin
            lvl_n = lvl_q;
            snd_n = snd_q;
        end
    end
`else
    logic unused_replay;
    assign unused_replay = replay;
    assign go    = start;
    assign lvl_n = clamp_level(level, MAX_LVL);
    assign snd_n = sound;
`endif

    assign next_cnt = note_cnt + 5'd1;

    tick_prescaler #(
        .CLK_DIV(CLK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .clr  (entry),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= StIdle;
            lvl_q      <= '0;
            snd_q      <= '0;
            note_cnt   <= '0;
            tick_cnt   <= '0;
            entry      <= 1'b0;
            play_index <= '0;
            tone_en    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            entry <= 1'b0;
            done  <= 1'b0;
            if (abort) begin
                // Abort also suppresses a start requested in the same cycle.
                entry      <= (state != StIdle);
                state      <= StIdle;
                note_cnt   <= '0;
                tick_cnt   <= '0;
                play_index <= '0;
                tone_en    <= 1'b0;
                busy       <= 1'b0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (go) begin
                            lvl_q      <= lvl_n;
                            snd_q      <= snd_n;
                            state      <= StNote;
                            entry      <= 1'b1;
                            note_cnt   <= '0;
                            tick_cnt   <= '0;
                            play_index <= note_index(5'd0, lvl_n, snd_n);
                            tone_en    <= 1'b1;
                            busy       <= 1'b1;
                        end
                    end
                    StNote: begin
                        if (tick) begin
                            if (tick_cnt == NOTE_LAST) begin
                                tick_cnt <= '0;
                                entry    <= 1'b1;
                                tone_en  <= 1'b0;
                                if (note_cnt == lvl_q) begin
                                    state <= StFin;
                                    done  <= 1'b1;
                                end else begin
                                    state <= StGap;
                                end
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                        end
                    end
                    StGap: begin
                        if (tick) begin
                            if (tick_cnt == GAP_LAST) begin
                                tick_cnt   <= '0;
                                entry      <= 1'b1;
                                state      <= StNote;
                                note_cnt   <= next_cnt;
                                play_index <= note_index(next_cnt, lvl_q, snd_q);
                                tone_en    <= 1'b1;
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                        end
                    end
                    StFin: begin
                        state      <= StIdle;
                        entry      <= 1'b1;
                        play_index <= '0;
                        busy       <= 1'b0;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: doc/melody_seq.md
MELODY_SEQ -- requirements
Module: melody_seq

Interface
REQ-001 Parameter CLK_DIV, default 50000, clock cycles per timing tick.
REQ-002 Parameter NOTE_TICKS, default 400, ticks a note sounds.
REQ-003 Parameter GAP_TICKS, default 100, silent ticks between notes.
REQ-004 Parameter MAX_SCALE, default 15, maximum number of scale notes before the target.
REQ-005 Port clk, input, 1, single system clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1, synchronous, active-high reset.
REQ-007 Port start, input, 1, request to play a sequence; sampled in IDLE only.
REQ-008 Port abort, input, 1, terminates playback immediately.
REQ-009 Port level, input, 5, number of ascending scale notes played before the target.
REQ-010 Port sound, input, 4, target note index played last.
REQ-011 Port replay, input, 1, replay request; honoured only under REPLAY_EN.
REQ-012 Port play_index, output, 5, tone-table index of the current note.
REQ-013 Port tone_en, output, 1, high while a note sounds; enables the buzzer divider.
REQ-014 Port busy, output, 1, high from sequence accept until return to IDLE.
REQ-015 Port done, output, 1, one-cycle pulse on normal completion.

Function
REQ-016 FSM states SHALL be IDLE, NOTE, GAP and FIN.
REQ-017 In IDLE, start=1 SHALL latch level (clamped to MAX_SCALE) and sound, then enter NOTE on the next cycle.
REQ-018 busy, tone_en and play_index SHALL be valid in the cycle after start is sampled (latency 1).
REQ-019 Note k (0-based) SHALL have play_index=k for k<level_latched; the final note SHALL have play_index={1'b0,sound_latched}.
REQ-020 level=0 SHALL play only the target note.
REQ-021 NOTE SHALL last exactly NOTE_TICKS*CLK_DIV cycles with tone_en=1, then go to GAP, or to FIN after the final note.
REQ-022 GAP SHALL last exactly GAP_TICKS*CLK_DIV cycles with tone_en=0 and play_index held, then advance to the next note.
REQ-023 FIN SHALL last one cycle with done=1 and tone_en=0, then return to IDLE with busy=0.
REQ-024 The tick prescaler SHALL restart at 0 on every state entry, so durations are exact from entry.
REQ-025 start while busy SHALL be ignored; latched level and sound SHALL not change mid-sequence.
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE next cycle: tone_en=0, busy=0, no done pulse.
REQ-027 If abort and start are asserted together in IDLE, abort SHALL win and nothing starts.
REQ-028 The note counter SHALL be 5 bits and SHALL never wrap, because the clamp bounds it.

Reset
REQ-029 reset SHALL override all inputs, including abort.
REQ-030 reset SHALL force state IDLE, play_index=0, tone_en=0, busy=0 and done=0 on the next edge.
REQ-031 reset SHALL clear the latched level/sound, the note counter and the prescaler, including mid-note.

Configuration
REQ-032 Macro MELODY_REPLAY_EN defined: replay=1 in IDLE SHALL restart the last latched sequence without re-sampling level or sound.
REQ-033 If start and replay are asserted together, start SHALL take priority.
REQ-034 After reset with no prior start, replay SHALL play level 0 with sound 0.
REQ-035 Macro MELODY_REPLAY_EN undefined: replay SHALL be ignored and no replay logic synthesised.

Structure
REQ-036 Package melody_pkg SHALL hold the state enum and the default tick constants.
REQ-037 Sub-module tick_prescaler SHALL generate the one-cycle tick and take a synchronous clear on state entry.

Verification (CLK_DIV=4, NOTE_TICKS=2, GAP_TICKS=1, MAX_SCALE=15)
REQ-038 start, level=2, sound=9 -> play_index 0,1,9.
  - Each note: 8 cycles tone_en=1.
  - Two 4-cycle gaps.
  - done pulses once at cycle 33 after start, then busy=0.
REQ-039 start, level=0, sound=3 -> single 8-cycle note at index 3, then done.
REQ-040 start, level=20 -> 16 notes (indices 0-14, then target); busy spans 16*8+15*4+1 cycles.
REQ-041 abort at cycle 5 of note 1 -> next cycle tone_en=0, busy=0, no done pulse.
REQ-042 reset mid-GAP -> all outputs 0 next cycle; a following start plays correctly from note 0.
REQ-043 MELODY_REPLAY_EN: after REQ-038, change sound=4, assert replay -> replays 0,1,9; start-while-busy ignored.
